// File: rtl/stage_memory_if.sv
// -----------------------------------------------------------------------------
// stage_memory_if
// Data-memory bus between the MEM pipeline stage (master) and the data memory
// (slave).
//
// Handshake: the master raises req together with we/addr/wdata/be and holds
// all of them stable until it samples ack=1 on a rising edge. That edge ends
// the access. rdata is valid only in the cycle where ack=1. The master may
// withdraw req without ack (timeout or reset), and an ack that arrives while
// req is low is ignored.
//
// Signals
//   req    master->slave  1   access request, held until ack
//   we     master->slave  1   1 = store, 0 = load
//   addr   master->slave  32  word-aligned address
//   wdata  master->slave  32  store data replicated across byte lanes
//   be     master->slave  4   byte enables
//   ack    slave->master  1   access complete
//   rdata  slave->master  32  read word, valid with ack
// -----------------------------------------------------------------------------
interface stage_memory_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata
  );
endinterface

// File: rtl/stage_memory.sv
// -----------------------------------------------------------------------------
// stage_memory
// MEM pipeline stage. It takes the EX/MEM operands and performs loads and
// stores over the data-memory bus (stage_memory_if, req/ack handshake). It
// registers the MEM/WB pipeline outputs that feed stage_writeback. While a bus
// access is pending it holds the upstream pipeline with mem_stall. Load data
// is lane-selected and then sign- or zero-extended before it reaches WB.
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses with cause 2'b10. When it is undefined, the low offset bits are
// ignored for half/word accesses.
//
// Parameters
//   TIMEOUT_CYCLES  cycles spent waiting for ack before a bus-timeout fault
//                   (1..255)
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   mem_*                EX/MEM inputs (valid, read, write, funct3, alu_result,
//                        write_data, result_src, pc_plus_4, imm_ext, rd,
//                        reg_write)
//   mem_stall            combinational; upstream holds mem_* while 1
//   dmem                 data-memory bus, master side
//   wb_*                 MEM/WB pipeline register outputs
//   mem_fault            one-cycle pulse, aligned with the faulting wb_valid
//   mem_fault_cause      01 bus timeout, 10 misaligned; held until next fault
//   dbg_state            current FSM state (0 IDLE, 1 WAIT_ACK)
// -----------------------------------------------------------------------------
module stage_memory #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            mem_funct3,
  input  logic [31:0]           mem_alu_result,
  input  logic [31:0]           mem_write_data,
  input  logic [1:0]            mem_result_src,
  input  logic [31:0]           mem_pc_plus_4,
  input  logic [31:0]           mem_imm_ext,
  input  logic [4:0]            mem_rd,
  input  logic                  mem_reg_write,
  output logic                  mem_stall,
  stage_memory_if.master        dmem,
  output logic                  wb_valid,
  output logic [1:0]            wb_result_src,
  output logic [31:0]           wb_alu_result,
  output logic [31:0]           wb_read_result,
  output logic [31:0]           wb_pc_plus_4,
  output logic [31:0]           wb_imm_ext,
  output logic [4:0]            wb_rd,
  output logic                  wb_reg_write,
  output logic                  mem_fault,
  output logic [1:0]            mem_fault_cause,
  output logic                  dbg_state
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_ACK = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  localparam logic [7:0] CNT_LAST     = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] CAUSE_TMO    = 2'b01;
  localparam logic [1:0] CAUSE_MISAL  = 2'b10;

  // state
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wb_valid_q, wb_valid_d;
  logic [1:0]  wb_result_src_q, wb_result_src_d;
  logic [31:0] wb_alu_result_q, wb_alu_result_d;
  logic [31:0] wb_read_result_q, wb_read_result_d;
  logic [31:0] wb_pc_plus_4_q, wb_pc_plus_4_d;
  logic [31:0] wb_imm_ext_q, wb_imm_ext_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;

  // decode
  logic        access;
  logic        is_load;
  size_e       size;
  logic        trap;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign access  = mem_valid & (mem_read | mem_write);
  // A request with both read and write set is handled as a load.
  assign is_load = mem_read;

  // Access size. The unsigned funct3 codes exist only for loads, and any
  // undefined code is handled as a word access.
  always_comb begin
    size = SZ_W;
    case (mem_funct3)
      3'b000:  size = SZ_B;
      3'b001:  size = SZ_H;
      3'b100:  size = is_load ? SZ_B : SZ_W;
      3'b101:  size = is_load ? SZ_H : SZ_W;
      default: size = SZ_W;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((size == SZ_H) &  mem_alu_result[0]) |
                      ((size == SZ_W) & (mem_alu_result[1:0] != 2'b00));
  assign trap       = access & misaligned;
`else
  assign trap       = 1'b0;
`endif

  // Byte-lane steering of enables and store data.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = mem_write_data;
    case (size)
      SZ_B: begin
        lane_be    = 4'b0001 << mem_alu_result[1:0];
        lane_wdata = {4{mem_write_data[7:0]}};
      end
      SZ_H: begin
        lane_be    = mem_alu_result[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{mem_write_data[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = mem_write_data;
      end
    endcase
  end

  // Load lane select and extension. funct3[2] set means zero-extend.
  always_comb begin
    ld_byte = dmem.rdata[7:0];
    case (mem_alu_result[1:0])
      2'd0:    ld_byte = dmem.rdata[7:0];
      2'd1:    ld_byte = dmem.rdata[15:8];
      2'd2:    ld_byte = dmem.rdata[23:16];
      default: ld_byte = dmem.rdata[31:24];
    endcase
    ld_half = mem_alu_result[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    ld_ext  = dmem.rdata;
    case (size)
      SZ_B:    ld_ext = {{24{ld_byte[7] & ~mem_funct3[2]}}, ld_byte};
      SZ_H:    ld_ext = {{16{ld_half[15] & ~mem_funct3[2]}}, ld_half};
      default: ld_ext = dmem.rdata;
    endcase
  end

  // next state / outputs
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    req_d            = req_q;
    we_d             = we_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    be_d             = be_q;
    wb_valid_d       = 1'b0;
    wb_result_src_d  = wb_result_src_q;
    wb_alu_result_d  = wb_alu_result_q;
    wb_read_result_d = wb_read_result_q;
    wb_pc_plus_4_d   = wb_pc_plus_4_q;
    wb_imm_ext_d     = wb_imm_ext_q;
    wb_rd_d          = wb_rd_q;
    wb_reg_write_d   = wb_reg_write_q;
    fault_d          = 1'b0;
    cause_d          = cause_q;
    mem_stall        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (access && !trap) begin
          mem_stall = 1'b1;
          req_d     = 1'b1;
          we_d      = ~is_load;
          addr_d    = {mem_alu_result[31:2], 2'b00};
          be_d      = lane_be;
          wdata_d   = is_load ? 32'h0 : lane_wdata;
          cnt_d     = 8'd0;
          state_d   = S_WAIT_ACK;
        end else begin
          // Either a plain pass-through or a misaligned access that completes
          // at once without touching the bus.
          wb_valid_d       = mem_valid;
          wb_result_src_d  = mem_result_src;
          wb_alu_result_d  = mem_alu_result;
          wb_read_result_d = 32'h0;
          wb_pc_plus_4_d   = mem_pc_plus_4;
          wb_imm_ext_d     = mem_imm_ext;
          wb_rd_d          = mem_rd;
          wb_reg_write_d   = mem_reg_write;
          if (trap) begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
            fault_d        = 1'b1;
            cause_d        = CAUSE_MISAL;
          end
        end
      end

      S_WAIT_ACK: begin
        if (dmem.ack || cnt_q == CNT_LAST) begin
          // The instruction leaves the stage on this edge, either with data
          // or as a timeout fault. Stall drops so upstream can advance.
          req_d            = 1'b0;
          state_d          = S_IDLE;
          cnt_d            = 8'd0;
          wb_valid_d       = 1'b1;
          wb_result_src_d  = mem_result_src;
          wb_alu_result_d  = mem_alu_result;
          wb_pc_plus_4_d   = mem_pc_plus_4;
          wb_imm_ext_d     = mem_imm_ext;
          wb_rd_d          = mem_rd;
          wb_reg_write_d   = mem_reg_write;
          wb_read_result_d = (dmem.ack && is_load) ? ld_ext : 32'h0;
          if (!dmem.ack) begin
            wb_reg_write_d = 1'b0;
            fault_d        = 1'b1;
            cause_d        = CAUSE_TMO;
          end
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= 8'd0;
      req_q            <= 1'b0;
      we_q             <= 1'b0;
      addr_q           <= 32'h0;
      wdata_q          <= 32'h0;
      be_q             <= 4'h0;
      wb_valid_q       <= 1'b0;
      wb_result_src_q  <= 2'b00;
      wb_alu_result_q  <= 32'h0;
      wb_read_result_q <= 32'h0;
      wb_pc_plus_4_q   <= 32'h0;
      wb_imm_ext_q     <= 32'h0;
      wb_rd_q          <= 5'd0;
      wb_reg_write_q   <= 1'b0;
      fault_q          <= 1'b0;
      cause_q          <= 2'b00;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      req_q            <= req_d;
      we_q             <= we_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      be_q             <= be_d;
      wb_valid_q       <= wb_valid_d;
      wb_result_src_q  <= wb_result_src_d;
      wb_alu_result_q  <= wb_alu_result_d;
      wb_read_result_q <= wb_read_result_d;
      wb_pc_plus_4_q   <= wb_pc_plus_4_d;
      wb_imm_ext_q     <= wb_imm_ext_d;
      wb_rd_q          <= wb_rd_d;
      wb_reg_write_q   <= wb_reg_write_d;
      fault_q          <= fault_d;
      cause_q          <= cause_d;
    end
  end

  assign dmem.req        = req_q;
  assign dmem.we         = we_q;
  assign dmem.addr       = addr_q;
  assign dmem.wdata      = wdata_q;
  assign dmem.be         = be_q;
  assign wb_valid        = wb_valid_q;
  assign wb_result_src   = wb_result_src_q;
  assign wb_alu_result   = wb_alu_result_q;
  assign wb_read_result  = wb_read_result_q;
  assign wb_pc_plus_4    = wb_pc_plus_4_q;
  assign wb_imm_ext      = wb_imm_ext_q;
  assign wb_rd           = wb_rd_q;
  assign wb_reg_write    = wb_reg_write_q;
  assign mem_fault       = fault_q;
  assign mem_fault_cause = cause_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_stage_memory.sv
// -----------------------------------------------------------------------------
// tb_stage_memory
// Directed bench for stage_memory built with TIMEOUT_CYCLES=4. Inputs change on
// the falling edge. Combinational outputs are checked 1 ns later, and
// registered outputs are checked 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_stage_memory;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_pc_plus_4;
  logic [31:0] mem_imm_ext;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_stall;
  logic        wb_valid;
  logic [1:0]  wb_result_src;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_read_result;
  logic [31:0] wb_pc_plus_4;
  logic [31:0] wb_imm_ext;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        mem_fault;
  logic [1:0]  mem_fault_cause;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  stage_memory_if dmem();

  stage_memory #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_valid       (mem_valid),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_funct3      (mem_funct3),
    .mem_alu_result  (mem_alu_result),
    .mem_write_data  (mem_write_data),
    .mem_result_src  (mem_result_src),
    .mem_pc_plus_4   (mem_pc_plus_4),
    .mem_imm_ext     (mem_imm_ext),
    .mem_rd          (mem_rd),
    .mem_reg_write   (mem_reg_write),
    .mem_stall       (mem_stall),
    .dmem            (dmem),
    .wb_valid        (wb_valid),
    .wb_result_src   (wb_result_src),
    .wb_alu_result   (wb_alu_result),
    .wb_read_result  (wb_read_result),
    .wb_pc_plus_4    (wb_pc_plus_4),
    .wb_imm_ext      (wb_imm_ext),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write),
    .mem_fault       (mem_fault),
    .mem_fault_cause (mem_fault_cause),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    mem_valid      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_funct3     = 3'b000;
    mem_alu_result = 32'h0;
    mem_write_data = 32'h0;
    mem_result_src = 2'b00;
    mem_pc_plus_4  = 32'h0;
    mem_imm_ext    = 32'h0;
    mem_rd         = 5'd0;
    mem_reg_write  = 1'b0;
    dmem.ack       = 1'b0;
    dmem.rdata     = 32'h0;
  endtask

  task automatic drive_mem(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data);
    mem_valid      = 1'b1;
    mem_read       = rd_en;
    mem_write      = wr_en;
    mem_funct3     = f3;
    mem_alu_result = addr;
    mem_write_data = data;
    mem_result_src = 2'b01;
    mem_pc_plus_4  = 32'h0000_1004;
    mem_imm_ext    = 32'h0000_0010;
    mem_rd         = 5'd7;
    mem_reg_write  = rd_en;
  endtask

  task automatic drive_ack(input logic [31:0] rdata);
    dmem.ack   = 1'b1;
    dmem.rdata = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fall();
    @(negedge clk);
  endtask

  // stimulus
  initial begin
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    fall();
    rst = 1'b0;
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_req", 32'(dmem.req), 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    chk("rst_cause", 32'(mem_fault_cause), 32'd0);
    chk("rst_read_result", wb_read_result, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);

    // lb at 0x103, ack in the first request cycle
    fall();
    drive_mem(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
    #1;
    chk("lb_stall_accept", 32'(mem_stall), 32'd1);
    tick();
    chk("lb_req", 32'(dmem.req), 32'd1);
    chk("lb_we", 32'(dmem.we), 32'd0);
    chk("lb_addr", dmem.addr, 32'h0000_0100);
    chk("lb_wb_bubble", 32'(wb_valid), 32'd0);
    chk("lb_state_wait", 32'(dbg_state), 32'd1);
    fall();
    drive_ack(32'h80FF_0000);
    #1;
    chk("lb_stall_ack", 32'(mem_stall), 32'd0);
    tick();
    chk("lb_wb_valid", 32'(wb_valid), 32'd1);
    chk("lb_read_result", wb_read_result, 32'hFFFF_FF80);
    chk("lb_wb_rd", 32'(wb_rd), 32'd7);
    chk("lb_reg_write", 32'(wb_reg_write), 32'd1);
    chk("lb_req_drop", 32'(dmem.req), 32'd0);
    chk("lb_no_fault", 32'(mem_fault), 32'd0);

    // lhu at 0x102
    fall();
    drive_idle();
    drive_mem(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0);
    tick();
    fall();
    drive_ack(32'hBEEF_1234);
    tick();
    chk("lhu_read_result", wb_read_result, 32'h0000_BEEF);

    // lbu at 0x101 with read and write both set: handled as a load
    fall();
    drive_idle();
    drive_mem(1'b1, 1'b1, 3'b100, 32'h0000_0101, 32'hFFFF_FFFF);
    tick();
    chk("rw_we_is_load", 32'(dmem.we), 32'd0);
    fall();
    drive_ack(32'h0000_9A00);
    tick();
    chk("lbu_read_result", wb_read_result, 32'h0000_009A);

    // sh at 0x206
    fall();
    drive_idle();
    drive_mem(1'b0, 1'b1, 3'b001, 32'h0000_0206, 32'h1234_ABCD);
    tick();
    chk("sh_be", 32'(dmem.be), 32'h0000_000C);
    chk("sh_wdata", dmem.wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(dmem.we), 32'd1);
    chk("sh_addr", dmem.addr, 32'h0000_0204);
    fall();
    drive_ack(32'hDEAD_BEEF);
    tick();
    chk("sh_wb_valid", 32'(wb_valid), 32'd1);
    chk("sh_read_result_zero", wb_read_result, 32'h0);

    // sb at 0x201
    fall();
    drive_idle();
    drive_mem(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_0055);
    tick();
    chk("sb_be", 32'(dmem.be), 32'h0000_0002);
    chk("sb_wdata", dmem.wdata, 32'h5555_5555);
    fall();
    drive_ack(32'h0);
    tick();

    // sw at 0x208
    fall();
    drive_idle();
    drive_mem(1'b0, 1'b1, 3'b010, 32'h0000_0208, 32'hCAFE_0001);
    tick();
    chk("sw_be", 32'(dmem.be), 32'h0000_000F);
    chk("sw_wdata", dmem.wdata, 32'hCAFE_0001);
    fall();
    drive_ack(32'h0);
    tick();

    // ALU ops: valid 1,0,1, no stalls
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    for (int i = 0; i < 3; i++) begin
      fall();
      drive_idle();
      mem_valid      = (i != 1);
      mem_alu_result = 32'h0000_0011 + 32'(i);
      mem_rd         = 5'd3;
      mem_reg_write  = 1'b1;
      #1;
      chk("alu_stall", 32'(mem_stall), 32'd0);
      tick();
      chk("alu_wb_valid", 32'(wb_valid), exp_q.pop_front());
    end
    chk("alu_wb_alu_result", wb_alu_result, 32'h0000_0013);

    // lw with no ack: times out after 4 request cycles
    fall();
    drive_idle();
    drive_mem(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      fall();
      chk("tmo_req_held", 32'(dmem.req), 32'd1);
      if (i < 3) chk("tmo_stall", 32'(mem_stall), 32'd1);
      tick();
    end
    chk("tmo_req_drop", 32'(dmem.req), 32'd0);
    chk("tmo_wb_valid", 32'(wb_valid), 32'd1);
    chk("tmo_reg_write", 32'(wb_reg_write), 32'd0);
    chk("tmo_fault", 32'(mem_fault), 32'd1);
    chk("tmo_cause", 32'(mem_fault_cause), 32'd1);
    fall();
    drive_idle();
    tick();
    chk("tmo_fault_pulse", 32'(mem_fault), 32'd0);
    chk("tmo_cause_held", 32'(mem_fault_cause), 32'd1);

    // lw at 0x101 (misaligned word)
    fall();
    drive_mem(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
`ifdef MISALIGN_TRAP_EN
    #1;
    chk("mis_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("mis_no_req", 32'(dmem.req), 32'd0);
    chk("mis_wb_valid", 32'(wb_valid), 32'd1);
    chk("mis_reg_write", 32'(wb_reg_write), 32'd0);
    chk("mis_fault", 32'(mem_fault), 32'd1);
    chk("mis_cause", 32'(mem_fault_cause), 32'd2);
`else
    tick();
    chk("mis_req", 32'(dmem.req), 32'd1);
    chk("mis_addr", dmem.addr, 32'h0000_0100);
    chk("mis_be", 32'(dmem.be), 32'h0000_000F);
    fall();
    drive_ack(32'hCAFE_F00D);
    tick();
    chk("mis_read_result", wb_read_result, 32'hCAFE_F00D);
    chk("mis_no_fault", 32'(mem_fault), 32'd0);
    chk("mis_cause_held", 32'(mem_fault_cause), 32'd1);
`endif

    // reset in the middle of an access, then a late ack
    fall();
    drive_idle();
    drive_mem(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
    tick();
    chk("rstmid_req", 32'(dmem.req), 32'd1);
    fall();
    rst = 1'b1;
    tick();
    chk("rstmid_req_drop", 32'(dmem.req), 32'd0);
    chk("rstmid_state", 32'(dbg_state), 32'd0);
    fall();
    rst = 1'b0;
    drive_idle();
    drive_ack(32'h1234_5678);
    tick();
    chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("late_ack_req", 32'(dmem.req), 32'd0);
    chk("late_ack_read_result", wb_read_result, 32'h0);
    fall();
    drive_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
